nfifo_gen: RTL and testbench

- Parametrised successor to the fixed 12-bit nFIFO sample buffer, generalised in width and depth.
- Two run-time modes:
  - mode=0: handshake FIFO with push/pop, full/empty, fill count and error pulses.
  - mode=1: programmable delay line. The output is the sample written delay_sel advances earlier (1..DEPTH).
- Sits between the sample source and downstream consumers in the datapath; one clock domain.

---
 rtl/nfifo_gen.sv | 151 +++++++++++++++
 tb/tb_nfifo_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nfifo_gen.sv
// nfifo_gen: parametrised sample buffer with two run-time modes.
//   mode=0: handshake FIFO (push/pop, full/empty, fill count, error pulses).
//   mode=1: programmable delay line; output is the sample advanced D-1
//           advances earlier, registered one edge later (D-advance delay).
// Single clock domain, synchronous active-high reset.
module nfifo_gen #(
  parameter int WIDTH    = 12,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AFULL_TH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic [AW:0]      delay_sel,
  input  logic [WIDTH-1:0] datain,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dataout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic {
    MODE_FIFO  = 1'b0,
    MODE_DELAY = 1'b1
  } mode_t;

  mode_t mode_q, mode_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [AW:0]      count_d;
  logic [WIDTH-1:0] dataout_d;
  logic             dv_d, ovf_d, unf_d;
  logic             mem_we;
  logic             mode_change;
  logic             push_ok, pop_ok;
  logic [AW:0]      d_eff;
  logic [AW-1:0]    dly_raddr;

  // Mode register: tracks the requested mode one cycle behind
  always_ff @(posedge clk) begin
    if (reset) mode_q <= mode_t'(mode);
    else       mode_q <= mode_d;
  end

  // Next mode is simply the requested mode; a mismatch marks a flush cycle
  always_comb begin
    mode_d      = mode_t'(mode);
    mode_change = (mode_d != mode_q);
  end

  // Status flags derived from the count register
  always_comb begin
    full        = (count == DEPTH_C);
    empty       = (count == '0);
    almost_full = (count >= AFULL_C);
  end

  // Effective delay: 0 behaves as 1, anything above DEPTH clamps to DEPTH
  always_comb begin
    if (delay_sel == '0)          d_eff = ONE_C;
    else if (delay_sel > DEPTH_C) d_eff = DEPTH_C;
    else                          d_eff = delay_sel;
    // D=DEPTH truncates to 0 here, giving wr_ptr+1 mod DEPTH as required
    dly_raddr = wr_ptr - d_eff[AW-1:0] + AW'(1);
  end

  // Datapath control: flush, FIFO handshake or delay-line advance
  always_comb begin
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    dv_d      = 1'b0;
    mem_we    = 1'b0;
    dataout_d = dataout;
    count_d   = count;
    wr_ptr_d  = wr_ptr;
    rd_ptr_d  = rd_ptr;

    if (mode_change) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (mode_q == MODE_FIFO) begin
      pop_ok  = rd_en & ~empty;
      push_ok = wr_en & (~full | pop_ok);
      ovf_d   = wr_en & ~push_ok;
      unf_d   = rd_en & ~pop_ok;
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        dataout_d = mem[rd_ptr];
        dv_d      = 1'b1;
        rd_ptr_d  = rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count + ONE_C;
        2'b01:   count_d = count - ONE_C;
        default: count_d = count;
      endcase
    end else if (wr_en) begin
      mem_we    = 1'b1;
      dataout_d = (d_eff == ONE_C) ? datain : mem[dly_raddr];
      dv_d      = (count >= (d_eff - ONE_C));
      wr_ptr_d  = wr_ptr + AW'(1);
      if (!full) count_d = count + ONE_C;
    end
  end

  // Pointer, count and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dataout    <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      dataout    <= dataout_d;
      dout_valid <= dv_d;
      overflow   <= ovf_d;
      underflow  <= unf_d;
    end
  end

  // Storage write; reads above see the pre-write contents of the same slot
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[wr_ptr] <= datain;
  end

endmodule

// File: tb/tb_nfifo_gen.sv
// Directed self-checking bench for nfifo_gen (WIDTH=12, DEPTH=16).
module tb_nfifo_gen;

  logic        clk = 1'b0;
  logic        reset, mode, wr_en, rd_en;
  logic [4:0]  delay_sel;
  logic [11:0] datain;
  logic [11:0] dataout;
  logic        dout_valid, full, empty, almost_full, overflow, underflow;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  logic [11:0] hist [0:127];

  nfifo_gen #(.WIDTH(12), .DEPTH(16), .AW(4), .AFULL_TH(12)) dut (
    .clk(clk), .reset(reset), .mode(mode), .delay_sel(delay_sel),
    .datain(datain), .wr_en(wr_en), .rd_en(rd_en), .dataout(dataout),
    .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    datain = '0; delay_sel = 5'd1;
    tick; tick;
    reset = 1'b0;
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if ({full, empty, almost_full} !== 3'b010) begin errors++; $display("FAIL reset_flags: got %b expected 010", {full, empty, almost_full}); end
    checks++;
    if ({dataout, dout_valid, overflow, underflow} !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {dataout, dout_valid, overflow, underflow}); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      datain = 12'(i); wr_en = 1'b1;
      tick;
      checks++;
      if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
      checks++;
      if (almost_full !== (i >= 12)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, (i >= 12)); end
      checks++;
      if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 16)); end
    end
    datain = 12'h0AA; wr_en = 1'b1;
    tick;
    checks++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL overflow_push: got ovf=%b count=%0d expected ovf=1 count=16", overflow, count); end
    wr_en = 1'b0;
    tick;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse_end: got %b expected 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick;
      checks++;
      if ({dout_valid, dataout} !== {1'b1, 12'(i)}) begin errors++; $display("FAIL drain_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, dout_valid, dataout, 12'(i)); end
      checks++;
      if (count !== 5'(16 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 16 - i); end
    end
    rd_en = 1'b0;
    tick;
    checks++;
    if ({dout_valid, empty} !== 2'b01) begin errors++; $display("FAIL drain_end: got v=%b empty=%b expected v=0 empty=1", dout_valid, empty); end
    rd_en = 1'b1;
    tick;
    checks++;
    if ({underflow, dout_valid, dataout} !== {2'b10, 12'd16}) begin errors++; $display("FAIL underflow_pop: got unf=%b v=%b d=%h expected unf=1 v=0 d=010", underflow, dout_valid, dataout); end
    rd_en = 1'b0;
    tick;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_pulse_end: got %b expected 0", underflow); end
  endtask

  task automatic test_wrap;
    logic [11:0] q[$];
    logic [11:0] exp;
    for (int i = 0; i < 3; i++) begin
      datain = 12'h200 + 12'(i); wr_en = 1'b1; q.push_back(datain);
      tick;
    end
    for (int i = 0; i < 40; i++) begin
      datain = 12'h300 + 12'(i); wr_en = 1'b1; rd_en = 1'b1;
      exp = q.pop_front(); q.push_back(datain);
      tick;
      checks++;
      if ({dout_valid, dataout} !== {1'b1, exp}) begin errors++; $display("FAIL wrap_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, dout_valid, dataout, exp); end
      checks++;
      if ({count, overflow, underflow} !== {5'd3, 2'b00}) begin errors++; $display("FAIL wrap_state[%0d]: got count=%0d ovf=%b unf=%b expected 3 0 0", i, count, overflow, underflow); end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; exp = q.pop_front();
      tick;
      checks++;
      if (dataout !== exp) begin errors++; $display("FAIL wrap_tail[%0d]: got %h expected %h", i, dataout, exp); end
    end
    rd_en = 1'b0;
    tick;
  endtask

  task automatic test_simultaneous;
    datain = 12'h123; wr_en = 1'b1; rd_en = 1'b1;
    tick;
    checks++;
    if ({underflow, dout_valid, count} !== {2'b10, 5'd1}) begin errors++; $display("FAIL simul_empty: got unf=%b v=%b count=%0d expected 1 0 1", underflow, dout_valid, count); end
    rd_en = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      datain = 12'h400 + 12'(i);
      tick;
    end
    checks++;
    if ({full, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL simul_prefill: got full=%b count=%0d expected 1 16", full, count); end
    datain = 12'h5A5; wr_en = 1'b1; rd_en = 1'b1;
    tick;
    checks++;
    if ({dout_valid, dataout} !== {1'b1, 12'h123}) begin errors++; $display("FAIL simul_full_data: got v=%b d=%h expected v=1 d=123", dout_valid, dataout); end
    checks++;
    if ({overflow, full, count} !== {2'b01, 5'd16}) begin errors++; $display("FAIL simul_full_state: got ovf=%b full=%b count=%0d expected 0 1 16", overflow, full, count); end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick;
      checks++;
      if (dataout !== ((i < 15) ? 12'h401 + 12'(i) : 12'h5A5)) begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, dataout, ((i < 15) ? 12'h401 + 12'(i) : 12'h5A5)); end
    end
    rd_en = 1'b0;
    tick;
  endtask

  task automatic test_delay;
    reset = 1'b1; mode = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick;
    reset = 1'b0; delay_sel = 5'd5;
    for (int j = 0; j < 50; j++) begin
      datain = 12'(j); hist[j] = datain; wr_en = 1'b1;
      tick;
      checks++;
      if (dout_valid !== (j >= 4)) begin errors++; $display("FAIL dly5_valid[%0d]: got %b expected %b", j, dout_valid, (j >= 4)); end
      if (j >= 4) begin
        checks++;
        if (dataout !== 12'(j - 4)) begin errors++; $display("FAIL dly5_data[%0d]: got %h expected %h", j, dataout, 12'(j - 4)); end
      end
      checks++;
      if (count !== ((j < 15) ? 5'(j + 1) : 5'd16)) begin errors++; $display("FAIL dly5_count[%0d]: got %0d expected %0d", j, count, (j < 15) ? j + 1 : 16); end
    end
    delay_sel = 5'd1;
    for (int j = 50; j < 55; j++) begin
      if (j == 54) delay_sel = 5'd0;
      datain = 12'h600 + 12'(j); hist[j] = datain;
      tick;
      checks++;
      if ({dout_valid, dataout} !== {1'b1, 12'h600 + 12'(j)}) begin errors++; $display("FAIL dly1_data[%0d]: got v=%b d=%h expected v=1 d=%h", j, dout_valid, dataout, 12'h600 + 12'(j)); end
    end
    delay_sel = 5'd16;
    for (int j = 55; j < 61; j++) begin
      if (j == 60) delay_sel = 5'd31;
      datain = 12'h700 + 12'(j); hist[j] = datain;
      tick;
      checks++;
      if ({dout_valid, dataout} !== {1'b1, hist[j - 15]}) begin errors++; $display("FAIL dly16_data[%0d]: got v=%b d=%h expected v=1 d=%h", j, dout_valid, dataout, hist[j - 15]); end
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick;
    checks++;
    if ({dout_valid, underflow, overflow, dataout} !== {3'b000, hist[45]}) begin errors++; $display("FAIL dly_hold: got v=%b unf=%b ovf=%b d=%h expected 0 0 0 %h", dout_valid, underflow, overflow, dataout, hist[45]); end
    rd_en = 1'b0;
  endtask

  task automatic test_mode_toggle;
    reset = 1'b1; mode = 1'b0;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      datain = 12'h011 + 12'(i); wr_en = 1'b1;
      tick;
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    checks++;
    if ({count, dataout} !== {5'd5, 12'h011}) begin errors++; $display("FAIL toggle_pre: got count=%0d d=%h expected 5 011", count, dataout); end
    mode = 1'b1; delay_sel = 5'd16; datain = 12'hFFF; wr_en = 1'b1;
    tick;
    checks++;
    if ({count, empty, dout_valid, dataout} !== {5'd0, 2'b10, 12'h011}) begin errors++; $display("FAIL toggle_flush: got count=%0d empty=%b v=%b d=%h expected 0 1 0 011", count, empty, dout_valid, dataout); end
    for (int j = 0; j < 16; j++) begin
      datain = 12'h800 + 12'(j);
      tick;
      checks++;
      if (dout_valid !== (j == 15)) begin errors++; $display("FAIL toggle_d16_valid[%0d]: got %b expected %b", j, dout_valid, (j == 15)); end
    end
    checks++;
    if ({dataout, count} !== {12'h800, 5'd16}) begin errors++; $display("FAIL toggle_d16_data: got d=%h count=%0d expected 800 16", dataout, count); end
  endtask

  task automatic test_reset_midstream;
    wr_en = 1'b1; rd_en = 1'b1; reset = 1'b1;
    tick;
    checks++;
    if ({count, empty, dataout, dout_valid, overflow, underflow} !== {5'd0, 1'b1, 12'd0, 3'b000}) begin errors++; $display("FAIL rst_mid_delay: got count=%0d empty=%b d=%h v=%b ovf=%b unf=%b expected 0 1 0 0 0 0", count, empty, dataout, dout_valid, overflow, underflow); end
    mode = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      datain = 12'h0C0 + 12'(i); wr_en = 1'b1;
      tick;
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick;
    checks++;
    if (dataout !== 12'h0C0) begin errors++; $display("FAIL rst_mid_fifo_pre: got %h expected 0C0", dataout); end
    wr_en = 1'b1; rd_en = 1'b1; reset = 1'b1;
    tick;
    checks++;
    if ({count, empty, dataout, dout_valid, overflow, underflow} !== {5'd0, 1'b1, 12'd0, 3'b000}) begin errors++; $display("FAIL rst_mid_fifo: got count=%0d empty=%b d=%h v=%b ovf=%b unf=%b expected 0 1 0 0 0 0", count, empty, dataout, dout_valid, overflow, underflow); end
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_wrap;
    test_simultaneous;
    test_delay;
    test_mode_toggle;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
